counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Passive, cycle-accurate checker for the 32-bit 4-mode counter output interface (Q, RCO, LOAD).
- Sits beside the counter and observes the same clk, RESET, ENABLE, MODO and D the counter receives.
- Keeps its own prediction of the counter and flags mismatches with sticky error flags, a per-cycle ERROR pulse and a saturating error count.
- Used in block-level benches and as an optional on-chip self-check.

Parameters:
- WIDTH, 32, counter data width.
- ERR_CNT_W, 16, width of the error counter.
- STOP_ON_ERR, 0: 1 = freeze checking (HALT) after the first mismatch.
- RESYNC, 1: 1 = after a mismatch, the prediction re-bases on the observed DUT Q.

Ports:
- clk  input  1  clock
- RESET  input  1  synchronous active-high reset
- CHK_EN  input  1  checking enable; 0 = track only
- ENABLE  input  1  counter enable as driven to the DUT
- MODO  input  2  counter mode as driven to the DUT
- D  input  WIDTH  counter load data as driven to the DUT
- Q  input  WIDTH  DUT count output
- RCO  input  1  DUT ripple-carry-out
- LOAD  input  1  DUT load indicator
- ERROR  output  1  one-cycle pulse per mismatching cycle
- ERR_Q  output  1  sticky: Q mismatch seen
- ERR_RCO  output  1  sticky: RCO mismatch seen
- ERR_LOAD  output  1  sticky: LOAD mismatch seen
- ERR_COUNT  output  ERR_CNT_W  number of mismatching cycles, saturating
- EXP_Q  output  WIDTH  current predicted Q
- HALTED  output  1  checker is in HALT

Behaviour:
- Counter contract being checked. All DUT outputs are registered and update on the clk edge at which the inputs are sampled.
  - ENABLE=0: Q holds; RCO=0; LOAD=0.
  - MODO=00: Q+1 mod 2^WIDTH; RCO=1 iff old Q = all ones.
  - MODO=01: Q-1 mod 2^WIDTH; RCO=1 iff old Q = 0.
  - MODO=10: Q-3 mod 2^WIDTH; RCO=1 iff old Q < 3 (borrow).
  - MODO=11: Q=D; LOAD=1; RCO=0.
  - DUT reset values: Q=0, RCO=0, LOAD=0.
- Prediction registers exp_q, exp_rco, exp_load are updated every edge from the sampled ENABLE/MODO/D and the current base. The base is exp_q, or DUT Q when re-based (see OFF and mismatch rules).
- Compare: combinational each cycle, DUT {Q,RCO,LOAD} vs {exp_q,exp_rco,exp_load}. A mismatch is registered into ERROR and the sticky flags at the next edge, so ERROR rises 1 cycle after the bad DUT output is visible.
- Reset (RESET=1 at an edge), regardless of state: exp_q=0, exp_rco=0, exp_load=0, ERROR=0, all sticky flags=0, ERR_COUNT=0, HALTED=0, state = CHECK if CHK_EN else OFF. Reset mid-run discards all history. No compare occurs on a RESET edge.
- FSM:
  - OFF: no compare, ERROR=0. Prediction base is DUT Q, so the model tracks the DUT. CHK_EN=1 -> CHECK at the next edge; the first compare is on the following cycle.
  - CHECK: compare every cycle.
    - On mismatch: ERROR=1, set the sticky flag per mismatching field, ERR_COUNT+1 (saturates at all ones, no wrap).
    - If RESYNC=1, the next prediction uses DUT Q as base; otherwise exp_q continues.
    - If STOP_ON_ERR=1 and a mismatch occurs -> HALT.
    - CHK_EN=0 -> OFF; this takes priority over the mismatch transition, but the mismatch is still counted.
  - HALT: no compare; flags, ERR_COUNT and EXP_Q frozen; HALTED=1. Leaves only on RESET.
- Multiple fields mismatching in one cycle count once in ERR_COUNT and set each relevant sticky flag.
- EXP_Q is the exp_q register. Width rules: all arithmetic mod 2^WIDTH, and the borrow compare is unsigned.

Test Plan:
- Reset, CHK_EN=1, ENABLE=1, MODO=00 from Q=0 for 5 cycles, DUT model correct -> EXP_Q 1..5, ERROR never 1, ERR_COUNT=0.
- Load D=32'hFFFF_FFFE (MODO=11), then MODO=00 for 2 cycles -> LOAD=1 expected only on the load cycle; expected Q FFFF_FFFF then 0 with RCO=1 on the 0 cycle; a correct DUT gives no errors.
- Load D=2, MODO=10 -> expected Q=FFFF_FFFF, RCO=1. Inject a DUT Q of FFFF_FFFE -> ERROR pulse 1 cycle later, ERR_Q=1, ERR_RCO=0, ERR_COUNT=1. With RESYNC=1, the next MODO=10 predicts FFFF_FFFB.
- STOP_ON_ERR=1: inject a RCO glitch while ENABLE=0 -> ERR_RCO=1, HALTED=1. Further bad values leave ERR_COUNT=1. RESET clears everything, HALTED=0.
- CHK_EN=0 while the DUT jumps to arbitrary Q=1234 -> no ERROR. CHK_EN=1 then MODO=01 -> expects 1233, no error.
- ERR_CNT_W=2: force a mismatch on 5 consecutive cycles -> ERR_COUNT saturates at 3, ERROR high all 5 cycles.

Source files
------------

// File: rtl/counter_checker.sv
// Passive cycle-accurate checker for the 4-mode counter (Q/RCO/LOAD).
// It keeps its own prediction of the counter and records mismatches in sticky flags and a saturating error count.
module counter_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ERR_CNT_W   = 16,
  parameter bit          STOP_ON_ERR = 1'b0,
  parameter bit          RESYNC      = 1'b1
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 CHK_EN,
  input  logic                 ENABLE,
  input  logic [1:0]           MODO,
  input  logic [WIDTH-1:0]     D,
  input  logic [WIDTH-1:0]     Q,
  input  logic                 RCO,
  input  logic                 LOAD,
  output logic                 ERROR,
  output logic                 ERR_Q,
  output logic                 ERR_RCO,
  output logic                 ERR_LOAD,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [WIDTH-1:0]     EXP_Q,
  output logic                 HALTED
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_CHECK,
    ST_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     expQ_q, expQ_d;
  logic                 expRco_q, expRco_d;
  logic                 expLoad_q, expLoad_d;
  logic                 error_q, error_d;
  logic                 errQ_q, errQ_d;
  logic                 errRco_q, errRco_d;
  logic                 errLoad_q, errLoad_d;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;

  logic                 compare;
  logic                 misQ, misRco, misLoad, mismatch;
  logic [WIDTH-1:0]     base;

  assign compare  = (state_q == ST_CHECK);
  assign misQ     = compare && (Q != expQ_q);
  assign misRco   = compare && (RCO != expRco_q);
  assign misLoad  = compare && (LOAD != expLoad_q);
  assign mismatch = misQ || misRco || misLoad;

  // While off, or after a mismatch with RESYNC, the model continues from the DUT's own Q.
  assign base = ((state_q == ST_OFF) || (RESYNC && mismatch)) ? Q : expQ_q;

  always_comb begin
    expQ_d    = base;
    expRco_d  = 1'b0;
    expLoad_d = 1'b0;
    if (state_q == ST_HALT) begin
      expQ_d    = expQ_q;
      expRco_d  = expRco_q;
      expLoad_d = expLoad_q;
    end else if (ENABLE) begin
      case (MODO)
        2'b00: begin
          expQ_d   = base + WIDTH'(1);
          expRco_d = &base;
        end
        2'b01: begin
          expQ_d   = base - WIDTH'(1);
          expRco_d = (base == '0);
        end
        2'b10: begin
          expQ_d   = base - WIDTH'(3);
          expRco_d = (base < WIDTH'(3));
        end
        default: begin
          expQ_d    = D;
          expLoad_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    error_d    = mismatch;
    errQ_d     = errQ_q | misQ;
    errRco_d   = errRco_q | misRco;
    errLoad_d  = errLoad_q | misLoad;
    errCount_d = errCount_q;
    if (mismatch && (errCount_q != '1)) begin
      errCount_d = errCount_q + ERR_CNT_W'(1);
    end
  end

  // Dropping CHK_EN wins over the halt transition; the mismatch itself is still recorded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (CHK_EN) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!CHK_EN)                         state_d = ST_OFF;
        else if (STOP_ON_ERR && mismatch)    state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= CHK_EN ? ST_CHECK : ST_OFF;
      expQ_q     <= '0;
      expRco_q   <= 1'b0;
      expLoad_q  <= 1'b0;
      error_q    <= 1'b0;
      errQ_q     <= 1'b0;
      errRco_q   <= 1'b0;
      errLoad_q  <= 1'b0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      expQ_q     <= expQ_d;
      expRco_q   <= expRco_d;
      expLoad_q  <= expLoad_d;
      error_q    <= error_d;
      errQ_q     <= errQ_d;
      errRco_q   <= errRco_d;
      errLoad_q  <= errLoad_d;
      errCount_q <= errCount_d;
    end
  end

  assign ERROR     = error_q;
  assign ERR_Q     = errQ_q;
  assign ERR_RCO   = errRco_q;
  assign ERR_LOAD  = errLoad_q;
  assign ERR_COUNT = errCount_q;
  assign EXP_Q     = expQ_q;
  assign HALTED    = (state_q == ST_HALT);

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: three checker configurations watch a bench-modelled counter with injected faults.
// Expected checker outputs come from an arithmetic reference model of the checking rules.
module tb_counter_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chkEn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  modo = 2'b00;
  logic [31:0] d = '0;
  logic [31:0] dutQ = '0;
  logic        dutRco = 1'b0;
  logic        dutLoad = 1'b0;

  logic        error [3];
  logic        errQ [3];
  logic        errRco [3];
  logic        errLoad [3];
  logic [31:0] expQ [3];
  logic        halted [3];
  logic [15:0] errCnt0, errCnt1;
  logic [1:0]  errCnt2;

  int checkCount = 0;
  int passCount = 0;

  // Reference model state for the three configurations
  logic [31:0] mExpQ [3];
  logic        mExpRco [3], mExpLoad [3];
  logic        mErr [3], mErrQ [3], mErrRco [3], mErrLoad [3];
  logic        mChecking [3], mHalted [3];
  longint      mCount [3];
  longint      cntMax [3] = '{65535, 65535, 3};
  bit          stopCfg [3] = '{1'b0, 1'b1, 1'b0};
  bit          resyncCfg [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(32), .ERR_CNT_W(16), .STOP_ON_ERR(1'b0), .RESYNC(1'b1)) dut0 (
    .clk(clk), .RESET(rst), .CHK_EN(chkEn), .ENABLE(en), .MODO(modo), .D(d),
    .Q(dutQ), .RCO(dutRco), .LOAD(dutLoad),
    .ERROR(error[0]), .ERR_Q(errQ[0]), .ERR_RCO(errRco[0]), .ERR_LOAD(errLoad[0]),
    .ERR_COUNT(errCnt0), .EXP_Q(expQ[0]), .HALTED(halted[0]));

  counter_checker #(.WIDTH(32), .ERR_CNT_W(16), .STOP_ON_ERR(1'b1), .RESYNC(1'b1)) dut1 (
    .clk(clk), .RESET(rst), .CHK_EN(chkEn), .ENABLE(en), .MODO(modo), .D(d),
    .Q(dutQ), .RCO(dutRco), .LOAD(dutLoad),
    .ERROR(error[1]), .ERR_Q(errQ[1]), .ERR_RCO(errRco[1]), .ERR_LOAD(errLoad[1]),
    .ERR_COUNT(errCnt1), .EXP_Q(expQ[1]), .HALTED(halted[1]));

  counter_checker #(.WIDTH(32), .ERR_CNT_W(2), .STOP_ON_ERR(1'b0), .RESYNC(1'b0)) dut2 (
    .clk(clk), .RESET(rst), .CHK_EN(chkEn), .ENABLE(en), .MODO(modo), .D(d),
    .Q(dutQ), .RCO(dutRco), .LOAD(dutLoad),
    .ERROR(error[2]), .ERR_Q(errQ[2]), .ERR_RCO(errRco[2]), .ERR_LOAD(errLoad[2]),
    .ERR_COUNT(errCnt2), .EXP_Q(expQ[2]), .HALTED(halted[2]));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else passCount++;
  endtask

  // Counter contract with plain arithmetic: returns {nextQ, rco, load}
  function automatic logic [33:0] counterStep(input logic [31:0] q, input logic e,
                                              input logic [1:0] m, input logic [31:0] dv);
    longint two32 = 64'd4294967296;
    longint cur = longint'(q);
    longint nq;
    logic rco, ld;
    rco = 1'b0;
    ld  = 1'b0;
    nq  = cur;
    if (e) begin
      case (m)
        2'd0: begin nq = (cur + 1) % two32;         rco = (cur + 1 >= two32); end
        2'd1: begin nq = (cur - 1 + two32) % two32; rco = (cur < 1); end
        2'd2: begin nq = (cur - 3 + two32) % two32; rco = (cur < 3); end
        default: begin nq = longint'(dv); ld = 1'b1; end
      endcase
    end
    return {nq[31:0], rco, ld};
  endfunction

  task automatic modelStep(input int k, input logic [31:0] sQ, input logic sR, input logic sL);
    logic bq, br, bl, bad;
    logic [31:0] baseQ;
    logic [33:0] nx;
    if (rst) begin
      mExpQ[k] = '0; mExpRco[k] = 1'b0; mExpLoad[k] = 1'b0;
      mErr[k] = 1'b0; mErrQ[k] = 1'b0; mErrRco[k] = 1'b0; mErrLoad[k] = 1'b0;
      mCount[k] = 0; mChecking[k] = chkEn; mHalted[k] = 1'b0;
    end else if (mHalted[k]) begin
      mErr[k] = 1'b0;
    end else begin
      bq  = mChecking[k] && (sQ != mExpQ[k]);
      br  = mChecking[k] && (sR != mExpRco[k]);
      bl  = mChecking[k] && (sL != mExpLoad[k]);
      bad = bq || br || bl;
      mErr[k] = bad;
      mErrQ[k] = mErrQ[k] || bq;
      mErrRco[k] = mErrRco[k] || br;
      mErrLoad[k] = mErrLoad[k] || bl;
      if (bad && mCount[k] < cntMax[k]) mCount[k]++;
      baseQ = (!mChecking[k] || (bad && resyncCfg[k])) ? sQ : mExpQ[k];
      nx = counterStep(baseQ, en, modo, d);
      mExpQ[k] = nx[33:2]; mExpRco[k] = nx[1]; mExpLoad[k] = nx[0];
      if (mChecking[k]) begin
        if (!chkEn) mChecking[k] = 1'b0;
        else if (bad && stopCfg[k]) mHalted[k] = 1'b1;
      end else begin
        mChecking[k] = chkEn;
      end
    end
  endtask

  task automatic checkAll();
    logic [63:0] obsCnt;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       obsCnt = 64'(errCnt0);
        1:       obsCnt = 64'(errCnt1);
        default: obsCnt = 64'(errCnt2);
      endcase
      checkOutput($sformatf("d%0d_error", k),   64'(error[k]),   64'(mErr[k]));
      checkOutput($sformatf("d%0d_errq", k),    64'(errQ[k]),    64'(mErrQ[k]));
      checkOutput($sformatf("d%0d_errrco", k),  64'(errRco[k]),  64'(mErrRco[k]));
      checkOutput($sformatf("d%0d_errload", k), 64'(errLoad[k]), 64'(mErrLoad[k]));
      checkOutput($sformatf("d%0d_errcnt", k),  obsCnt,          64'(mCount[k]));
      checkOutput($sformatf("d%0d_expq", k),    64'(expQ[k]),    64'(mExpQ[k]));
      checkOutput($sformatf("d%0d_halted", k),  64'(halted[k]),  64'(mHalted[k]));
    end
  endtask

  // inj: 0 none, 1 force Q=injVal, 2 flip RCO, 3 flip LOAD, 4 Q ^= injVal
  task automatic applyStimulus(input logic r, input logic c, input logic e, input logic [1:0] m,
                               input logic [31:0] dv, input int inj, input logic [31:0] injVal);
    logic [31:0] sQ;
    logic sR, sL;
    logic [33:0] nx;
    rst = r; chkEn = c; en = e; modo = m; d = dv;
    sQ = dutQ; sR = dutRco; sL = dutLoad;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) modelStep(k, sQ, sR, sL);
    if (r) begin
      dutQ = '0; dutRco = 1'b0; dutLoad = 1'b0;
    end else begin
      nx = counterStep(sQ, e, m, dv);
      dutQ = nx[33:2]; dutRco = nx[1]; dutLoad = nx[0];
    end
    case (inj)
      1: dutQ = injVal;
      2: dutRco = ~dutRco;
      3: dutLoad = ~dutLoad;
      4: dutQ = dutQ ^ injVal;
      default: ;
    endcase
    checkAll();
  endtask

  initial begin
    logic r, c, e;
    logic [1:0] m;
    logic [31:0] dv, iv;
    int inj;

    applyStimulus(1, 1, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 2'd0, 0, 0, 0);
    checkOutput("plan_count5", 64'(expQ[0]), 64'd5);
    checkOutput("plan_noerr", 64'(errCnt0), 64'd0);

    applyStimulus(0, 1, 1, 2'd3, 32'hFFFF_FFFE, 0, 0);
    applyStimulus(0, 1, 1, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 1, 2'd0, 0, 0, 0);
    checkOutput("plan_wrap_rco", 64'(dutRco), 64'd1);

    applyStimulus(0, 1, 1, 2'd3, 32'd2, 0, 0);
    applyStimulus(0, 1, 1, 2'd2, 0, 1, 32'hFFFF_FFFE);
    applyStimulus(0, 1, 1, 2'd2, 0, 0, 0);
    checkOutput("plan_err_pulse", 64'(error[0]), 64'd1);
    checkOutput("plan_err_q", 64'(errQ[0]), 64'd1);
    checkOutput("plan_err_rco", 64'(errRco[0]), 64'd0);
    checkOutput("plan_err_cnt", 64'(errCnt0), 64'd1);
    checkOutput("plan_resync", 64'(expQ[0]), 64'hFFFF_FFFB);

    applyStimulus(1, 1, 0, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'd0, 0, 2, 0);
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'd0, 0, 4, 32'h55);
    applyStimulus(0, 1, 1, 2'd1, 0, 3, 0);
    checkOutput("plan_halted", 64'(halted[1]), 64'd1);
    checkOutput("plan_halt_rco", 64'(errRco[1]), 64'd1);
    checkOutput("plan_halt_cnt", 64'(errCnt1), 64'd1);
    applyStimulus(1, 1, 0, 2'd0, 0, 0, 0);
    checkOutput("plan_reset_halt", 64'(halted[1]), 64'd0);

    applyStimulus(0, 1, 0, 2'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 2'd0, 0, 1, 32'd1234);
    applyStimulus(0, 1, 1, 2'd1, 0, 0, 0);
    checkOutput("plan_off_track", 64'(expQ[0]), 64'd1233);
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 0);
    checkOutput("plan_off_noerr", 64'(error[0]), 64'd0);

    applyStimulus(1, 1, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 2'd0, 0, 4, 32'h1);
    checkOutput("plan_sat_cnt", 64'(errCnt2), 64'd3);
    checkOutput("plan_sat_err", 64'(error[2]), 64'd1);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 9) != 0);
      e = ($urandom_range(0, 4) != 0);
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       dv = 32'($urandom_range(0, 4));
        1:       dv = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        default: dv = $urandom;
      endcase
      inj = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 4)) : 0;
      iv = $urandom | 32'h1;
      applyStimulus(r, c, e, m, dv, inj, iv);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
